// File: rtl/lsu_ram_2way_if.sv
// Signal bundle between the load/store unit, the execute stage and the two-way data RAM.
// The master modport is the LSU side; slave is the execute-stage/RAM environment.
interface lsu_ram_2way_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  ls_req;
    logic                  ls_ready;
    logic                  ls_we;
    logic [1:0]            ls_size;
    logic                  ls_unsigned;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [31:0]           ls_wdata;
    logic                  ls_rvalid;
    logic [31:0]           ls_rdata;
    logic                  ls_err;

    logic                  ram_req;
    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic                  ram_rvalid;
    logic [31:0]           ram_rdata;
    logic                  ram_err;

    modport master (
        input  ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        input  ram_rvalid, ram_rdata, ram_err,
        output ls_ready, ls_rvalid, ls_rdata, ls_err,
        output ram_req, ram_we, ram_be, ram_addr, ram_wdata
    );

    modport slave (
        output ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        output ram_rvalid, ram_rdata, ram_err,
        input  ls_ready, ls_rvalid, ls_rdata, ls_err,
        input  ram_req, ram_we, ram_be, ram_addr, ram_wdata
    );
endinterface

// File: rtl/lsu_ram_2way.sv
// Load/store unit: aligns one byte/half/word access onto the 32-bit data RAM bus,
// waits for the response with an optional timeout and returns extended load data.
//
// state | meaning
// IDLE  | ready for a new access
// REQ   | ram_req asserted for this single cycle
// WAIT  | waiting for ram_rvalid, timeout counter running
// RESP  | ls_rvalid pulse with result or error
module lsu_ram_2way #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    lsu_ram_2way_if.master  bus
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            off_q, off_d;
    logic                  uns_q, uns_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  ram_req_q, ram_req_d;
    logic                  ram_we_q, ram_we_d;
    logic [3:0]            ram_be_q, ram_be_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;
    logic                  ls_rvalid_q, ls_rvalid_d;
    logic [31:0]           ls_rdata_q, ls_rdata_d;
    logic                  ls_err_q, ls_err_d;

    logic                  misaligned;
    logic [3:0]            be_new;
    logic [31:0]           wdata_new;

    function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    always_comb begin
        misaligned = (bus.ls_size == 2'b11)
                   | ((bus.ls_size == 2'b01) & bus.ls_addr[0])
                   | ((bus.ls_size == 2'b10) & (bus.ls_addr[1:0] != 2'b00));
        case (bus.ls_size)
            2'b00:   begin be_new = 4'b0001 << bus.ls_addr[1:0]; wdata_new = {4{bus.ls_wdata[7:0]}};  end
            2'b01:   begin be_new = 4'b0011 << bus.ls_addr[1:0]; wdata_new = {2{bus.ls_wdata[15:0]}}; end
            default: begin be_new = 4'b1111;                      wdata_new = bus.ls_wdata;             end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        off_d       = off_q;
        uns_d       = uns_q;
        cnt_d       = cnt_q;
        ram_req_d   = 1'b0;
        ram_we_d    = ram_we_q;
        ram_be_d    = ram_be_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = 32'h0;
        ls_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.ls_req) begin
                    we_d   = bus.ls_we;
                    size_d = bus.ls_size;
                    off_d  = bus.ls_addr[1:0];
                    uns_d  = bus.ls_unsigned;
                    if (misaligned) begin
                        state_d     = RESP;
                        ls_rvalid_d = 1'b1;
                        ls_err_d    = 1'b1;
                    end else begin
                        state_d     = REQ;
                        ram_req_d   = 1'b1;
                        ram_we_d    = bus.ls_we;
                        ram_be_d    = be_new;
                        ram_addr_d  = {bus.ls_addr[ADDR_WIDTH-1:2], 2'b00};
                        ram_wdata_d = wdata_new;
                    end
                end
            end
            REQ, WAIT: begin
                if (bus.ram_rvalid) begin
                    state_d     = RESP;
                    ls_rvalid_d = 1'b1;
                    ls_err_d    = bus.ram_err;
                    ls_rdata_d  = (bus.ram_err | we_q) ? 32'h0
                                : load_fmt(bus.ram_rdata, off_q, size_q, uns_q);
                end else if (state_q == REQ) begin
                    state_d = WAIT;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d     = RESP;
                    ls_rvalid_d = 1'b1;
                    ls_err_d    = 1'b1;
                end
                if (state_q == WAIT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            uns_q       <= 1'b0;
            cnt_q       <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= 4'h0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'h0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= 32'h0;
            ls_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            off_q       <= off_d;
            uns_q       <= uns_d;
            cnt_q       <= cnt_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_be_q    <= ram_be_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_err_q    <= ls_err_d;
        end
    end

    // Not ready while reset is held, even though the state register already reads IDLE.
    assign bus.ls_ready  = (state_q == IDLE) & reset;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_err    = ls_err_q;
    assign bus.ram_req   = ram_req_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_be    = ram_be_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
endmodule
